// File: rtl/lsu_req_if.sv
// MMU-side bus of the load/store request unit: level read/write requests with
// address, length and store data, answered by a one-cycle acknowledge with load data.
interface lsu_req_if #(
    parameter int C_DATA_L = 32,
    parameter int MADDR_L  = 32
);
    logic                c_re;
    logic                c_we;
    logic [MADDR_L-1:0]  c_raddr;
    logic [MADDR_L-1:0]  c_waddr;
    logic [1:0]          c_rlen;
    logic [1:0]          c_wlen;
    logic [C_DATA_L-1:0] c_din;
    logic [C_DATA_L-1:0] c_dout;
    logic                c_ack;

    modport master (
        output c_re, c_we, c_raddr, c_waddr, c_rlen, c_wlen, c_din,
        input  c_dout, c_ack
    );

    modport slave (
        input  c_re, c_we, c_raddr, c_waddr, c_rlen, c_wlen, c_din,
        output c_dout, c_ack
    );
endinterface

// File: rtl/lsu_req.sv
// Load/store request unit: accepts one MEM-stage access at a time, checks alignment,
// drives the MMU request until acknowledge or time-out, and extends load data for writeback.
module lsu_req #(
    parameter int C_DATA_L = 32,
    parameter int MADDR_L  = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [3:0]          ex_op,
    input  logic [MADDR_L-1:0]  ex_addr,
    input  logic [C_DATA_L-1:0] ex_wdata,
    input  logic [4:0]          ex_rd,
    input  logic                flush,
    output logic                wb_valid,
    output logic [C_DATA_L-1:0] wb_data,
    output logic [4:0]          wb_rd,
    output logic                st_done,
    output logic                exc_valid,
    output logic [1:0]          exc_code,
    output logic [MADDR_L-1:0]  exc_addr,
    lsu_req_if.master           mmu
);

    localparam int              CNT_W        = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]      EXC_MISALIGN = 2'd1;
    localparam logic [1:0]      EXC_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next;

    logic                accept_s;
    logic                misalign_s;
    logic                ack_s;
    logic                timeout_s;
    logic                bad_align_s;

    logic [CNT_W-1:0]    cnt_r;
    logic                is_store_r;
    logic                is_unsigned_r;
    logic [1:0]          len_r;
    logic [MADDR_L-1:0]  addr_r;
    logic [4:0]          rd_r;
    logic                flush_seen_r;
    logic [C_DATA_L-1:0] rdata_r;

    logic                ex_ready_r;
    logic                wb_valid_r;
    logic [C_DATA_L-1:0] wb_data_r;
    logic [4:0]          wb_rd_r;
    logic                st_done_r;
    logic                exc_valid_r;
    logic [1:0]          exc_code_r;
    logic [MADDR_L-1:0]  exc_addr_r;

    logic                c_re_r;
    logic                c_we_r;
    logic [MADDR_L-1:0]  c_raddr_r;
    logic [MADDR_L-1:0]  c_waddr_r;
    logic [1:0]          c_rlen_r;
    logic [1:0]          c_wlen_r;
    logic [C_DATA_L-1:0] c_din_r;

    // Size 2 is reserved and always faults; halves and words need natural alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            2'd3:    bad = (lsb != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Store data is right-justified; bytes beyond the access length are sent as zero.
    function automatic logic [31:0] store_mask(input logic [31:0] wdata, input logic [1:0] len);
        logic [31:0] d;
        case (len)
            2'd0:    d = {24'h00_0000, wdata[7:0]};
            2'd1:    d = {16'h0000, wdata[15:0]};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // MMU returns load bytes left-justified: shift down and sign/zero-extend from the top byte used.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] len,
                                                input logic uns);
        logic [31:0] d;
        case (len)
            2'd0:    d = {{24{raw[31] & ~uns}}, raw[31:24]};
            2'd1:    d = {{16{raw[31] & ~uns}}, raw[31:16]};
            default: d = raw;
        endcase
        return d;
    endfunction

    assign bad_align_s = is_misaligned(ex_op[2:1], ex_addr[1:0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        misalign_s = 1'b0;
        ack_s      = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (ex_valid) begin
                    if (bad_align_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        accept_s   = 1'b1;
                        state_next = S_REQ;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (mmu.c_ack) begin
                    ack_s      = 1'b1;
                    state_next = S_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Transaction context, MMU request drive and pipeline-facing result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= {CNT_W{1'b0}};
            is_store_r    <= 1'b0;
            is_unsigned_r <= 1'b0;
            len_r         <= 2'd0;
            addr_r        <= {MADDR_L{1'b0}};
            rd_r          <= 5'd0;
            flush_seen_r  <= 1'b0;
            rdata_r       <= {C_DATA_L{1'b0}};
            ex_ready_r    <= 1'b1;
            wb_valid_r    <= 1'b0;
            wb_data_r     <= {C_DATA_L{1'b0}};
            wb_rd_r       <= 5'd0;
            st_done_r     <= 1'b0;
            exc_valid_r   <= 1'b0;
            exc_code_r    <= 2'd0;
            exc_addr_r    <= {MADDR_L{1'b0}};
            c_re_r        <= 1'b0;
            c_we_r        <= 1'b0;
            c_raddr_r     <= {MADDR_L{1'b0}};
            c_waddr_r     <= {MADDR_L{1'b0}};
            c_rlen_r      <= 2'd0;
            c_wlen_r      <= 2'd0;
            c_din_r       <= {C_DATA_L{1'b0}};
        end else begin
            wb_valid_r  <= 1'b0;
            st_done_r   <= 1'b0;
            exc_valid_r <= 1'b0;
            ex_ready_r  <= (state_next == S_IDLE);

            if (misalign_s) begin
                exc_valid_r <= 1'b1;
                exc_code_r  <= EXC_MISALIGN;
                exc_addr_r  <= ex_addr;
            end

            if (accept_s) begin
                is_store_r    <= ex_op[3];
                is_unsigned_r <= ex_op[0];
                len_r         <= ex_op[2:1];
                addr_r        <= ex_addr;
                rd_r          <= ex_rd;
                flush_seen_r  <= 1'b0;
                cnt_r         <= {CNT_W{1'b0}};
                if (ex_op[3]) begin
                    c_we_r    <= 1'b1;
                    c_waddr_r <= ex_addr;
                    c_wlen_r  <= ex_op[2:1];
                    c_din_r   <= store_mask(ex_wdata, ex_op[2:1]);
                end else begin
                    c_re_r    <= 1'b1;
                    c_raddr_r <= ex_addr;
                    c_rlen_r  <= ex_op[2:1];
                end
            end else if (state_r == S_REQ) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            // A flush only masks the writeback; the access itself always runs to completion.
            if ((state_r == S_REQ) && flush) begin
                flush_seen_r <= 1'b1;
            end

            if (ack_s || timeout_s) begin
                c_re_r <= 1'b0;
                c_we_r <= 1'b0;
            end

            if (ack_s && !is_store_r) begin
                rdata_r <= mmu.c_dout;
            end

            if (timeout_s) begin
                exc_valid_r <= 1'b1;
                exc_code_r  <= EXC_TIMEOUT;
                exc_addr_r  <= addr_r;
            end

            if (state_r == S_RESP) begin
                if (is_store_r) begin
                    st_done_r <= 1'b1;
                end else if (!(flush_seen_r || flush)) begin
                    wb_valid_r <= 1'b1;
                    wb_data_r  <= load_extend(rdata_r, len_r, is_unsigned_r);
                    wb_rd_r    <= rd_r;
                end
            end
        end
    end

    assign ex_ready    = ex_ready_r;
    assign wb_valid    = wb_valid_r;
    assign wb_data     = wb_data_r;
    assign wb_rd       = wb_rd_r;
    assign st_done     = st_done_r;
    assign exc_valid   = exc_valid_r;
    assign exc_code    = exc_code_r;
    assign exc_addr    = exc_addr_r;

    assign mmu.c_re    = c_re_r;
    assign mmu.c_we    = c_we_r;
    assign mmu.c_raddr = c_raddr_r;
    assign mmu.c_waddr = c_waddr_r;
    assign mmu.c_rlen  = c_rlen_r;
    assign mmu.c_wlen  = c_wlen_r;
    assign mmu.c_din   = c_din_r;

endmodule

// File: tb/tb_lsu_req.sv
// Self-checking bench for lsu_req: directed scenarios plus randomized loads/stores
// compared against a byte-level reference model, with a configurable MMU responder.
module tb_lsu_req;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [3:0]  ex_op = 4'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        st_done;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic [31:0] exc_addr;

    lsu_req_if #(.C_DATA_L(32), .MADDR_L(32)) bus ();

    lsu_req #(.C_DATA_L(32), .MADDR_L(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .st_done(st_done),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr), .mmu(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // MMU responder: acks after ack_delay request cycles unless no_ack is set.
    int          ack_delay = 1;
    logic        no_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        mmu_ack = 1'b0;
    logic [31:0] mmu_dout = 32'd0;
    int          req_cnt = 0;

    assign bus.c_ack  = mmu_ack | stray_ack;
    assign bus.c_dout = mmu_dout;

    always @(posedge clk) begin
        #1;
        if (bus.c_re || bus.c_we) begin
            req_cnt = req_cnt + 1;
            mmu_ack = !no_ack && (req_cnt == ack_delay);
        end else begin
            req_cnt = 0;
            mmu_ack = 1'b0;
        end
    end

    // Monitor: running totals sampled mid-cycle; scenarios work on deltas.
    int re_cycles = 0, we_cycles = 0, re_rises = 0, unstable = 0;
    int wb_count = 0, st_count = 0, exc_count = 0, wb_cyc = 0, st_cyc = 0;
    logic [31:0] got_wb_data, got_eaddr, seen_raddr, seen_waddr, seen_din;
    logic [4:0]  got_wb_rd;
    logic [1:0]  got_code, seen_rlen, seen_wlen;
    logic        prev_re = 1'b0, prev_we = 1'b0;
    logic [35:0] prev_rreq = 36'd0;
    logic [67:0] prev_wreq = 68'd0;

    always @(negedge clk) begin
        if (bus.c_re) begin
            re_cycles++;
            seen_raddr = bus.c_raddr;
            seen_rlen  = bus.c_rlen;
            if (!prev_re) re_rises++;
            if (prev_re && prev_rreq !== {bus.c_raddr, 2'b00, bus.c_rlen}) unstable++;
        end
        if (bus.c_we) begin
            we_cycles++;
            seen_waddr = bus.c_waddr;
            seen_wlen  = bus.c_wlen;
            seen_din   = bus.c_din;
            if (prev_we && prev_wreq !== {bus.c_waddr, bus.c_din, 2'b00, bus.c_wlen}) unstable++;
        end
        if (wb_valid)  begin wb_count++; wb_cyc = cyc; got_wb_data = wb_data; got_wb_rd = wb_rd; end
        if (st_done)   begin st_count++; st_cyc = cyc; end
        if (exc_valid) begin exc_count++; got_code = exc_code; got_eaddr = exc_addr; end
        prev_re   = bus.c_re;
        prev_we   = bus.c_we;
        prev_rreq = {bus.c_raddr, 2'b00, bus.c_rlen};
        prev_wreq = {bus.c_waddr, bus.c_din, 2'b00, bus.c_wlen};
    end

    int b_re, b_we, b_rise, b_wb, b_st, b_exc, b_uns;

    task automatic snap();
        b_re = re_cycles; b_we = we_cycles; b_rise = re_rises; b_uns = unstable;
        b_wb = wb_count;  b_st = st_count;  b_exc = exc_count;
    endtask

    // Reference model helpers, written from byte counts rather than the RTL encoding.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd3) ? 4 : 0;
    endfunction

    function automatic logic [31:0] byte_mask(input int nb);
        return (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input int nb, input logic uns);
        logic [31:0] v;
        v = raw & byte_mask(nb);
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~byte_mask(nb);
        return v;
    endfunction

    task automatic issue(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, output int acc);
        int n;
        n = 0;
        while (ex_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (ex_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL issue_ready: ex_ready=%b required 1", ex_ready);
        end
        ex_valid = 1'b1; ex_op = {st, sz, un}; ex_addr = a; ex_wdata = wd; ex_rd = rd;
        @(posedge clk); #1;
        acc = cyc;
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (ex_ready !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL wait_idle: ex_ready=%b required 1", ex_ready); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        logic [99:0] bus_bits;
        logic [70:0] out_bits;
        repeat (2) @(posedge clk);
        #1;
        bus_bits = {bus.c_raddr, bus.c_waddr, bus.c_rlen, bus.c_wlen, bus.c_din};
        out_bits = {wb_data, wb_rd, exc_code, exc_addr};
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ex_ready); end
        checks++; if ({bus.c_re, bus.c_we, wb_valid, st_done, exc_valid} !== 5'b0) begin
            errors++; $display("FAIL rst_pulses: got %b required 00000", {bus.c_re, bus.c_we, wb_valid, st_done, exc_valid}); end
        checks++; if (bus_bits !== 100'd0) begin errors++; $display("FAIL rst_bus: got %h required 0", bus_bits); end
        checks++; if (out_bits !== 71'd0) begin errors++; $display("FAIL rst_out: got %h required 0", out_bits); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        int acc;
        snap(); ack_delay = 3; no_ack = 1'b0; mmu_dout = 32'h8000_0000;
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 5'd7, acc);
        wait_idle(20);
        checks++; if (got_wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", got_wb_data); end
        checks++; if (seen_rlen !== 2'd0 || seen_raddr !== 32'h103) begin
            errors++; $display("FAIL lb_req: len=%0d addr=%h required 0/103", seen_rlen, seen_raddr); end
        checks++; if (re_cycles - b_re != 3) begin errors++; $display("FAIL lb_re_cycles: got %0d required 3", re_cycles - b_re); end
        checks++; if (re_rises - b_rise != 1 || unstable != b_uns) begin
            errors++; $display("FAIL lb_req_stable: rises=%0d changes=%0d required 1/0", re_rises - b_rise, unstable - b_uns); end
        checks++; if (wb_count - b_wb != 1 || got_wb_rd !== 5'd7) begin
            errors++; $display("FAIL lb_wb: pulses=%0d rd=%0d required 1/7", wb_count - b_wb, got_wb_rd); end
        checks++; if (wb_cyc - acc != 4) begin errors++; $display("FAIL lb_latency: got %0d required 4", wb_cyc - acc); end
    endtask

    task automatic test_lh();
        int acc;
        ack_delay = 1; mmu_dout = 32'h8001_0000;
        snap();
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'd0, 5'd3, acc);
        wait_idle(20);
        checks++; if (got_wb_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h required 00008001", got_wb_data); end
        checks++; if (wb_cyc - acc != 2) begin errors++; $display("FAIL lhu_latency: got %0d required 2", wb_cyc - acc); end
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'd0, 5'd4, acc);
        wait_idle(20);
        checks++; if (got_wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h required ffff8001", got_wb_data); end
        checks++; if (seen_rlen !== 2'd1 || wb_count - b_wb != 2) begin
            errors++; $display("FAIL lh_len: len=%0d pulses=%0d required 1/2", seen_rlen, wb_count - b_wb); end
    endtask

    task automatic test_sw();
        int acc;
        snap(); ack_delay = 2;
        issue(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, acc);
        wait_idle(20);
        checks++; if (seen_wlen !== 2'd3 || seen_waddr !== 32'h20 || seen_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_req: len=%0d addr=%h din=%h required 3/20/deadbeef", seen_wlen, seen_waddr, seen_din); end
        checks++; if (we_cycles - b_we != 2 || re_cycles != b_re) begin
            errors++; $display("FAIL sw_we_cycles: we=%0d re=%0d required 2/0", we_cycles - b_we, re_cycles - b_re); end
        checks++; if (st_count - b_st != 1 || st_cyc - acc != 3 || wb_count != b_wb) begin
            errors++; $display("FAIL sw_done: pulses=%0d lat=%0d wb=%0d required 1/3/0", st_count - b_st, st_cyc - acc, wb_count - b_wb); end
    endtask

    task automatic test_misaligned();
        int acc;
        snap();
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0022, 32'd0, 5'd1, acc);
        checks++; if (exc_valid !== 1'b1 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL mis_pulse: exc_valid=%b ex_ready=%b required 1/1", exc_valid, ex_ready); end
        checks++; if (exc_code !== 2'd1 || exc_addr !== 32'h22) begin
            errors++; $display("FAIL mis_code: code=%0d addr=%h required 1/22", exc_code, exc_addr); end
        @(posedge clk); #1;
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL mis_width: exc_valid=%b required 0", exc_valid); end
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'd5, 5'd0, acc);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5'd0, acc);
        wait_idle(5);
        checks++; if (re_cycles + we_cycles != b_re + b_we || exc_count - b_exc != 3) begin
            errors++; $display("FAIL mis_noreq: req_cycles=%0d excs=%0d required 0/3", re_cycles + we_cycles - b_re - b_we, exc_count - b_exc); end
    endtask

    task automatic test_timeout();
        int acc;
        snap(); no_ack = 1'b1;
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'd0, 5'd9, acc);
        wait_idle(30);
        no_ack = 1'b0;
        checks++; if (re_cycles - b_re != TO) begin errors++; $display("FAIL to_cycles: got %0d required %0d", re_cycles - b_re, TO); end
        checks++; if (exc_count - b_exc != 1 || got_code !== 2'd2 || got_eaddr !== 32'h40) begin
            errors++; $display("FAIL to_exc: n=%0d code=%0d addr=%h required 1/2/40", exc_count - b_exc, got_code, got_eaddr); end
        checks++; if (wb_count != b_wb || st_count != b_st || bus.c_re !== 1'b0) begin
            errors++; $display("FAIL to_quiet: wb=%0d st=%0d c_re=%b required 0/0/0", wb_count - b_wb, st_count - b_st, bus.c_re); end
    endtask

    task automatic test_flush();
        int acc;
        snap(); ack_delay = 3; mmu_dout = 32'h1234_5678;
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0044, 32'd0, 5'd2, acc);
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        wait_idle(20);
        checks++; if (re_cycles - b_re != 3 || wb_count != b_wb) begin
            errors++; $display("FAIL flush_load: re=%0d wb=%0d required 3/0", re_cycles - b_re, wb_count - b_wb); end
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0045, 32'h0000_00AA, 5'd0, acc);
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        wait_idle(20);
        checks++; if (st_count - b_st != 1) begin errors++; $display("FAIL flush_store: st=%0d required 1", st_count - b_st); end
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0048, 32'd0, 5'd2, acc);
        wait_idle(20);
        checks++; if (wb_count - b_wb != 1 || got_wb_data !== 32'h1234_5678) begin
            errors++; $display("FAIL flush_clear: wb=%0d data=%h required 1/12345678", wb_count - b_wb, got_wb_data); end
    endtask

    task automatic test_stray_ack();
        snap();
        stray_ack = 1'b1; @(posedge clk); #1; stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (wb_count + st_count + exc_count != b_wb + b_st + b_exc || ex_ready !== 1'b1 || re_cycles != b_re) begin
            errors++; $display("FAIL stray_ack: pulses=%0d ex_ready=%b required 0/1", wb_count + st_count + exc_count - b_wb - b_st - b_exc, ex_ready); end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        snap(); ack_delay = 1; mmu_dout = 32'hFF00_0000;
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'd0, 5'd1, a0);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'd0, 5'd2, a1);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'd0, 5'd3, a2);
        wait_idle(20);
        checks++; if (a1 - a0 != 3 || a2 - a1 != 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d required 3,3", a1 - a0, a2 - a1); end
        checks++; if (wb_count - b_wb != 3 || got_wb_data !== 32'hFFFF_FFFF || got_wb_rd !== 5'd3) begin
            errors++; $display("FAIL b2b_wb: n=%0d data=%h rd=%0d required 3/ffffffff/3", wb_count - b_wb, got_wb_data, got_wb_rd); end
    endtask

    task automatic test_random();
        int acc, nb, dly;
        logic st, un, aligned;
        logic [1:0] sz;
        logic [31:0] a, wd, raw, exp_v;
        logic [4:0] rd;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
            a = $urandom; wd = $urandom; raw = $urandom; dly = $urandom_range(1, 4);
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            nb = nbytes(sz);
            aligned = (nb != 0) && ((a % 32'(nb)) == 32'd0);
            ack_delay = dly;
            mmu_dout = (nb == 0) ? 32'd0 : ((raw & byte_mask(nb)) << (8 * (4 - nb)));
            snap();
            issue(st, sz, un, a, wd, rd, acc);
            wait_idle(20);
            if (!aligned) begin
                checks++; if (exc_count - b_exc != 1 || got_code !== 2'd1 || got_eaddr !== a || re_cycles + we_cycles != b_re + b_we) begin
                    errors++; $display("FAIL rnd_mis[%0d]: n=%0d code=%0d addr=%h required 1/1/%h", i, exc_count - b_exc, got_code, got_eaddr, a); end
            end else if (st) begin
                checks++; if (seen_waddr !== a || seen_wlen !== 2'(nb - 1) || seen_din !== (wd & byte_mask(nb))) begin
                    errors++; $display("FAIL rnd_st_req[%0d]: addr=%h len=%0d din=%h required %h/%0d/%h", i, seen_waddr, seen_wlen, seen_din, a, nb - 1, wd & byte_mask(nb)); end
                checks++; if (st_count - b_st != 1 || st_cyc - acc != dly + 1 || we_cycles - b_we != dly || wb_count != b_wb) begin
                    errors++; $display("FAIL rnd_st_done[%0d]: n=%0d lat=%0d we=%0d required 1/%0d/%0d", i, st_count - b_st, st_cyc - acc, we_cycles - b_we, dly + 1, dly); end
            end else begin
                exp_v = model_load(raw, nb, un);
                checks++; if (wb_count - b_wb != 1 || got_wb_data !== exp_v || got_wb_rd !== rd) begin
                    errors++; $display("FAIL rnd_ld[%0d]: n=%0d data=%h rd=%0d required 1/%h/%0d", i, wb_count - b_wb, got_wb_data, got_wb_rd, exp_v, rd); end
                checks++; if (seen_raddr !== a || seen_rlen !== 2'(nb - 1) || re_cycles - b_re != dly || wb_cyc - acc != dly + 1) begin
                    errors++; $display("FAIL rnd_ld_req[%0d]: addr=%h len=%0d re=%0d lat=%0d required %h/%0d/%0d/%0d", i, seen_raddr, seen_rlen, re_cycles - b_re, wb_cyc - acc, a, nb - 1, dly, dly + 1); end
            end
            checks++; if (unstable != b_uns) begin errors++; $display("FAIL rnd_stable[%0d]: changes=%0d required 0", i, unstable - b_uns); end
        end
    endtask

    task automatic test_rst_mid();
        int acc;
        logic [99:0] bus_bits;
        logic [70:0] out_bits;
        ack_delay = 5; mmu_dout = 32'hAB00_0000;
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0300, 32'd0, 5'd6, acc);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        bus_bits = {bus.c_raddr, bus.c_waddr, bus.c_rlen, bus.c_wlen, bus.c_din};
        out_bits = {wb_data, wb_rd, exc_code, exc_addr};
        checks++; if (bus.c_re !== 1'b0 || ex_ready !== 1'b1 || bus_bits !== 100'd0) begin
            errors++; $display("FAIL rst_mid_bus: c_re=%b ex_ready=%b bus=%h required 0/1/0", bus.c_re, ex_ready, bus_bits); end
        checks++; if (out_bits !== 71'd0) begin errors++; $display("FAIL rst_mid_out: got %h required 0", out_bits); end
        @(posedge clk); #1;
        rst = 1'b0;
        snap();
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (wb_count + st_count + exc_count != b_wb + b_st + b_exc || re_cycles != b_re) begin
            errors++; $display("FAIL rst_mid_discard: pulses=%0d re=%0d required 0/0", wb_count + st_count + exc_count - b_wb - b_st - b_exc, re_cycles - b_re); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lh();
        test_sw();
        test_misaligned();
        test_timeout();
        test_flush();
        test_stray_ack();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_req.md
# lsu_req

Load/store request unit between the pipeline MEM stage and the memory management unit. Accepts one load or store at a time from the execute/memory boundary, checks alignment, drives the MMU's level request and length/data ports, waits for acknowledge, then right-justifies and sign- or zero-extends load data for writeback. Stalls the pipeline while a transaction is outstanding and reports misalignment and bus time-out as exceptions.

## Interface
- C_DATA_L, 32, CPU data width (fixed at 32 for this revision).
- MADDR_L, 32, byte address width.
- TIMEOUT, 64, cycles to wait for c_ack before aborting (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  op present on ex_* this cycle.
- ex_ready  out  1  unit idle and able to accept; pipeline stalls when 0.
- ex_op  in  4  {store, size[1:0], unsigned}; size 0=byte, 1=half, 3=word, 2 reserved.
- ex_addr  in  MADDR_L  byte address.
- ex_wdata  in  C_DATA_L  store data, right-justified.
- ex_rd  in  5  destination register tag for loads.
- flush  in  1  suppress writeback of the current load.
- wb_valid  out  1  one-cycle pulse, load data valid.
- wb_data  out  C_DATA_L  extended load data.
- wb_rd  out  5  tag of completed load.
- st_done  out  1  one-cycle pulse, store acknowledged.
- exc_valid  out  1  one-cycle pulse, exception.
- exc_code  out  2  1=misaligned, 2=bus time-out.
- exc_addr  out  MADDR_L  faulting address.
- c_re, c_we  out  1  MMU read/write request, level, held until ack.
- c_raddr, c_waddr  out  MADDR_L  MMU addresses.
- c_rlen, c_wlen  out  2  byte count minus one.
- c_din  out  C_DATA_L  store data, byte at lowest address in [7:0].
- c_dout  in  C_DATA_L  load data, left-justified, first byte in [31:24], unused bytes zero.
- c_ack  in  1  one-cycle completion pulse from MMU.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: ex_ready=1. On ex_valid: latch op/addr/wdata/rd; len = size. Misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size=2): stay IDLE, pulse exc_valid, exc_code=1, exc_addr=addr next cycle; no MMU request. Otherwise go REQ.
- REQ: ex_ready=0; assert c_re (load) or c_we (store) with registered address, len, data; clear timeout counter on entry, increment every cycle without c_ack.
- c_ack in REQ: drop request next cycle, go RESP, capture c_dout for loads.
- Counter reaching TIMEOUT-1 with no ack: drop request, pulse exc_valid, exc_code=2, go IDLE; no wb_valid/st_done.
- RESP (one cycle): loads: data = c_dout >> (8*(3-len)); sign-extend from bit 8*(len+1)-1 unless unsigned; pulse wb_valid unless flush was seen since acceptance. Stores: pulse st_done. Return to IDLE.
- flush never cancels a memory access in flight; stores always complete.
- c_ack in IDLE or RESP is ignored.

## Timing
- Reset: state IDLE; ex_ready=1; c_re=c_we=0; addresses, lens, c_din, wb_data, wb_rd, exc_code, exc_addr = 0; all pulses 0.
- Accept at edge N: c_re/c_we high from N+1. ack seen at edge M: request low from M+1, wb_valid/st_done high for cycle M+1 to M+2, ex_ready high again from M+2.
- Zero-wait MMU (ack in first REQ cycle): accept-to-wb_valid = 2 cycles, throughput one op per 3 cycles.
- Misaligned: exc_valid for exactly one cycle after acceptance; ex_ready stays 1.
- Request held at constant address/len/data for the whole REQ state (single rising edge per transaction).
- rst mid-transaction: request drops immediately, pending result discarded.

## Test plan
- LB addr 0x103, c_dout=0x80000000, ack after 3 cycles -> wb_data=0xFFFFFF80, c_rlen=0, c_re high exactly 3 cycles.
- LHU addr 0x10, c_dout=0x80010000 -> wb_data=0x00008001; LH same -> 0xFFFF8001.
- SW addr 0x20, ex_wdata=0xDEADBEEF -> c_we, c_wlen=3, c_din=0xDEADBEEF, st_done one cycle after ack.
- LW addr 0x22 -> exc_valid, exc_code=1, exc_addr=0x22, c_re never asserted.
- LW with no ack, TIMEOUT=8 -> c_re high 8 cycles, exc_code=2, no wb_valid, ex_ready returns.
- LW with flush during REQ -> c_re still acknowledged, no wb_valid; rst asserted mid-REQ -> all outputs at reset values same cycle.
